// File: rtl/spu_issue_unit.sv
// spu_issue_unit: dual-issue front end for the SPU execution core.
//
// Takes a program-ordered pair of predecoded instructions, holds it in a
// one-pair buffer and steers each slot to the even or odd pipe. Issue is
// blocked on RAW/WAW hazards against a per-register latency scoreboard.
// Slot 1 never issues ahead of slot 0. A branch flush kills the buffer.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   in_valid / in_ready   pair handshake from fetch/predecode
//   flush                 kill buffered, unissued instructions
//   in_pc                 PC of slot 0 (slot 1 is in_pc+4)
//   inS_*                 predecoded fields of slot S (S = 0, 1)
//   *_ep / *_op           registered even/odd pipe bundles
//   pc_op                 PC of the last instruction issued to the odd pipe
//
// Optional: define ISSUE_STATS_EN to add saturating 32-bit counters
// stat_dual, stat_single and stat_stall.

module spu_issue_unit #(
   parameter int unsigned     NUM_REGS = 128,
   parameter int unsigned     LAT_W    = 4,
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     OP_W     = 11,
   parameter logic [OP_W-1:0] NOP_OPC  = 11'h201,
   parameter logic [OP_W-1:0] LNOP_OPC = 11'h001
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [31:0]       in0_word,
   input  logic [OP_W-1:0]   in0_opcode,
   input  logic              in0_pipe,
   input  logic [LAT_W-1:0]  in0_lat,
   input  logic              in0_wr_en_rt,
   input  logic              in0_ls_wr,
   input  logic [6:0]        in0_ra, in0_rb, in0_rc, in0_rt,
   input  logic [2:0]        in0_src_use,
   input  logic [31:0]       in1_word,
   input  logic [OP_W-1:0]   in1_opcode,
   input  logic              in1_pipe,
   input  logic [LAT_W-1:0]  in1_lat,
   input  logic              in1_wr_en_rt,
   input  logic              in1_ls_wr,
   input  logic [6:0]        in1_ra, in1_rb, in1_rc, in1_rt,
   input  logic [2:0]        in1_src_use,
   output logic [OP_W-1:0]   opcode_ep, opcode_op,
   output logic [6:0]        ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep,
   output logic [6:0]        ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op,
   output logic [6:0]        I7_ep, I7_op,
   output logic [9:0]        I10_ep, I10_op,
   output logic [15:0]       I16_ep, I16_op,
   output logic [17:0]       I18_ep, I18_op,
   output logic              wr_en_rt_ep, wr_en_rt_op,
   output logic              ls_wr_en_op,
   output logic [PC_W-1:0]   pc_op
`ifdef ISSUE_STATS_EN
   ,
   output logic [31:0]       stat_dual,
   output logic [31:0]       stat_single,
   output logic [31:0]       stat_stall
`endif
);

   localparam logic [1:0] StEmpty  = 2'd0;
   localparam logic [1:0] StPair   = 2'd1;
   localparam logic [1:0] StSingle = 2'd2;

   // imm holds word[24:7]; bit numbering of the immediates is MSB-first (bit 0 = word[31]).
   typedef struct packed {
      logic [17:0]      imm;
      logic [OP_W-1:0]  opcode;
      logic             pipe;
      logic [LAT_W-1:0] lat;
      logic             wr_en_rt;
      logic             ls_wr;
      logic [6:0]       ra, rb, rc, rt;
      logic [2:0]       src_use;
   } slot_t;

   function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
      return (lat == '0) ? LAT_W'(1) : lat;
   endfunction

   function automatic logic slot_hazard(input slot_t s, input logic [LAT_W-1:0] b_ra,
                                        input logic [LAT_W-1:0] b_rb,
                                        input logic [LAT_W-1:0] b_rc,
                                        input logic [LAT_W-1:0] b_rt);
      return (s.src_use[2] && (b_ra != '0)) || (s.src_use[1] && (b_rb != '0)) ||
             (s.src_use[0] && (b_rc != '0)) || (s.wr_en_rt && (b_rt > eff_lat(s.lat)));
   endfunction

   slot_t            in_s0, in_s1, s0_q, s1_q, ep_s, op_s;
   logic [PC_W-1:0]  pc_q, op_pc;
   logic [1:0]       st_q, st_d;
   logic [LAT_W-1:0] busy_q [NUM_REGS];
   logic [LAT_W-1:0] busy_d [NUM_REGS];
   logic             haz0, haz1, intra, iss0, iss1, accept, ep_v, op_v;
   logic             unused_word;

   assign unused_word = ^{in0_word[31:25], in0_word[6:0], in1_word[31:25], in1_word[6:0]};

   assign in_s0 = '{imm: in0_word[24:7], opcode: in0_opcode, pipe: in0_pipe, lat: in0_lat,
                    wr_en_rt: in0_wr_en_rt, ls_wr: in0_ls_wr, ra: in0_ra, rb: in0_rb,
                    rc: in0_rc, rt: in0_rt, src_use: in0_src_use};
   assign in_s1 = '{imm: in1_word[24:7], opcode: in1_opcode, pipe: in1_pipe, lat: in1_lat,
                    wr_en_rt: in1_wr_en_rt, ls_wr: in1_ls_wr, ra: in1_ra, rb: in1_rb,
                    rc: in1_rc, rt: in1_rt, src_use: in1_src_use};

   assign haz0 = slot_hazard(s0_q, busy_q[s0_q.ra], busy_q[s0_q.rb], busy_q[s0_q.rc],
                             busy_q[s0_q.rt]);
   assign haz1 = slot_hazard(s1_q, busy_q[s1_q.ra], busy_q[s1_q.rb], busy_q[s1_q.rc],
                             busy_q[s1_q.rt]);

   // Slot 1 depends on (or overwrites) slot 0's result: cannot share the issue cycle.
   assign intra = s0_q.wr_en_rt &&
                  ((s1_q.src_use[2] && (s1_q.ra == s0_q.rt)) ||
                   (s1_q.src_use[1] && (s1_q.rb == s0_q.rt)) ||
                   (s1_q.src_use[0] && (s1_q.rc == s0_q.rt)) ||
                   (s1_q.wr_en_rt && (s1_q.rt == s0_q.rt)));

   assign iss0 = !flush && (st_q == StPair) && !haz0;
   assign iss1 = !flush &&
                 (((st_q == StPair) && !haz0 && !haz1 && (s0_q.pipe != s1_q.pipe) && !intra) ||
                  ((st_q == StSingle) && !haz1));

   // iss1 means every remaining valid slot leaves the buffer this cycle.
   assign in_ready = !reset && !flush && ((st_q == StEmpty) || iss1);
   assign accept   = in_valid && in_ready;

   always_comb begin
      ep_v  = (iss0 && !s0_q.pipe) || (iss1 && !s1_q.pipe);
      op_v  = (iss0 && s0_q.pipe) || (iss1 && s1_q.pipe);
      ep_s  = (iss0 && !s0_q.pipe) ? s0_q : s1_q;
      op_s  = (iss0 && s0_q.pipe) ? s0_q : s1_q;
      op_pc = (iss0 && s0_q.pipe) ? pc_q : pc_q + PC_W'(4);
   end

   always_comb begin
      st_d = st_q;
      if (flush) begin
         st_d = StEmpty;
      end else if (accept) begin
         st_d = StPair;
      end else if (st_q == StPair) begin
         if (iss0) st_d = iss1 ? StEmpty : StSingle;
      end else if (st_q == StSingle) begin
         if (iss1) st_d = StEmpty;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st_q <= StEmpty;
         s0_q <= '0;
         s1_q <= '0;
         pc_q <= '0;
      end else begin
         st_q <= st_d;
         if (accept) begin
            s0_q <= in_s0;
            s1_q <= in_s1;
            pc_q <= in_pc;
         end
      end
   end

   // Counters drain by one per cycle; a new write-back load overrides the decrement.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - LAT_W'(1) : '0;
         if (iss0 && s0_q.wr_en_rt && (s0_q.rt == 7'(r))) busy_d[r] = eff_lat(s0_q.lat);
         if (iss1 && s1_q.wr_en_rt && (s1_q.rt == 7'(r))) busy_d[r] = eff_lat(s1_q.lat);
      end
   end

   always_ff @(posedge clock) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_q[r] <= reset ? '0 : busy_d[r];
      end
   end

   always_ff @(posedge clock) begin
      if (reset || !ep_v) begin
         opcode_ep   <= NOP_OPC;
         ra_addr_ep  <= '0;
         rb_addr_ep  <= '0;
         rc_addr_ep  <= '0;
         rt_addr_ep  <= '0;
         I7_ep       <= '0;
         I10_ep      <= '0;
         I16_ep      <= '0;
         I18_ep      <= '0;
         wr_en_rt_ep <= 1'b0;
      end else begin
         opcode_ep   <= ep_s.opcode;
         ra_addr_ep  <= ep_s.ra;
         rb_addr_ep  <= ep_s.rb;
         rc_addr_ep  <= ep_s.rc;
         rt_addr_ep  <= ep_s.rt;
         I7_ep       <= ep_s.imm[13:7];
         I10_ep      <= ep_s.imm[16:7];
         I16_ep      <= ep_s.imm[15:0];
         I18_ep      <= ep_s.imm;
         wr_en_rt_ep <= ep_s.wr_en_rt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || !op_v) begin
         opcode_op   <= LNOP_OPC;
         ra_addr_op  <= '0;
         rb_addr_op  <= '0;
         rc_addr_op  <= '0;
         rt_addr_op  <= '0;
         I7_op       <= '0;
         I10_op      <= '0;
         I16_op      <= '0;
         I18_op      <= '0;
         wr_en_rt_op <= 1'b0;
         ls_wr_en_op <= 1'b0;
      end else begin
         opcode_op   <= op_s.opcode;
         ra_addr_op  <= op_s.ra;
         rb_addr_op  <= op_s.rb;
         rc_addr_op  <= op_s.rc;
         rt_addr_op  <= op_s.rt;
         I7_op       <= op_s.imm[13:7];
         I10_op      <= op_s.imm[16:7];
         I16_op      <= op_s.imm[15:0];
         I18_op      <= op_s.imm;
         wr_en_rt_op <= op_s.wr_en_rt;
         ls_wr_en_op <= op_s.ls_wr;
      end
   end

   // pc_op keeps the last odd-pipe PC while that pipe idles.
   always_ff @(posedge clock) begin
      if (reset) pc_op <= '0;
      else if (op_v) pc_op <= op_pc;
   end

`ifdef ISSUE_STATS_EN
   logic dual_ev, single_ev, stall_ev;

   assign dual_ev   = iss0 && iss1;
   assign single_ev = iss0 ^ iss1;
   assign stall_ev  = (st_q != StEmpty) && !iss0 && !iss1;

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_dual   <= '0;
         stat_single <= '0;
         stat_stall  <= '0;
      end else begin
         if (dual_ev && (stat_dual != '1)) stat_dual <= stat_dual + 32'd1;
         if (single_ev && (stat_single != '1)) stat_single <= stat_single + 32'd1;
         if (stall_ev && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
